// File: rtl/multiplicador_booth.sv
// Purpose: sequential radix-2 Booth multiplier for signed or unsigned operands, WIDTH+1 extended bits.
// Latency: done and P_out appear WIDTH+1 cycles after the accepting edge; one result every WIDTH+2 cycles.
// Backpressure: start is taken only in IDLE or DONE; start while busy is ignored and never stalls.
module multiplicador_booth #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   B_in,
  input  logic [WIDTH-1:0]   Q_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P_out
);

  // One extra bit lets a zero-extended unsigned operand be treated as a
  // positive two's-complement value, so both modes share the Booth datapath.
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [E-1:0]    a_reg;
  logic [E-1:0]    b_reg;
  logic [E-1:0]    q_reg;
  logic            qm1;
  logic [CW-1:0]   cnt;

  logic [E-1:0]    b_ext;
  logic [E-1:0]    q_ext;
  logic [E-1:0]    a_sum;
  logic [E-1:0]    a_step;
  logic [E-1:0]    q_step;
  logic            qm1_step;

  // Operand extension: sign bit replicated only in signed mode.
  always_comb begin
    b_ext = {signed_mode & B_in[WIDTH-1], B_in};
    q_ext = {signed_mode & Q_in[WIDTH-1], Q_in};
  end

  // One Booth step: add/subtract on {Q[0], q_-1}, then arithmetic shift of {A, Q, q_-1}.
  always_comb begin
    case ({q_reg[0], qm1})
      2'b10:   a_sum = a_reg - b_reg;
      2'b01:   a_sum = a_reg + b_reg;
      default: a_sum = a_reg;
    endcase
    a_step   = {a_sum[E-1], a_sum[E-1:1]};
    q_step   = {a_sum[0], q_reg[E-1:1]};
    qm1_step = q_reg[0];
  end

  // Control FSM and datapath registers; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= '0;
            b_reg <= b_ext;
            q_reg <= q_ext;
            qm1   <= 1'b0;
            cnt   <= CW'(E);
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          a_reg <= a_step;
          q_reg <= q_step;
          qm1   <= qm1_step;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Low 2*WIDTH bits of the 2E-bit product {A, Q}.
            P_out <= {a_step[WIDTH-2:0], q_step};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_booth.sv
// Purpose: self-checking bench for multiplicador_booth at WIDTH 4, 8 and 16.
// Latency: expects done WIDTH+1 edges after the accepting edge.
// Backpressure: exercises start during busy, back-to-back accept and reset abort.
module tb_multiplicador_booth;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  b4 = '0, q4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  b8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] b16 = '0, q16 = '0;
  logic        busy16, done16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp4q[$];
  logic [15:0] exp8q[$];
  logic [31:0] exp16q[$];

  typedef struct {
    logic       s;
    logic [3:0] b;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  multiplicador_booth #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .B_in(b4), .Q_in(q4), .busy(busy4), .done(done4), .P_out(p4)
  );

  multiplicador_booth #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .B_in(b8), .Q_in(q8), .busy(busy8), .done(done8), .P_out(p8)
  );

  multiplicador_booth #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .B_in(b16), .Q_in(q16), .busy(busy16), .done(done16), .P_out(p16)
  );

  // Reference product, truncated to 2*w bits.
  function automatic longint unsigned ref_mul(input logic s, input int w,
                                              input longint unsigned b,
                                              input longint unsigned q);
    longint sb, sq, p;
    sb = longint'(b);
    sq = longint'(q);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    if (s && q[w-1]) sq = sq - (longint'(1) << w);
    p = sb * sq;
    return longint'(p) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Scoreboards: every done pops one expected product.
  always @(negedge clk) begin
    if (done4) begin
      checks++;
      if (exp4q.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_done p=%h", p4);
      end else begin
        logic [7:0] e;
        e = exp4q.pop_front();
        if (p4 !== e || busy4 !== 1'b0) begin
          errors++;
          $display("FAIL w4_product got p=%h busy=%b want p=%h busy=0", p4, busy4, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (exp8q.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done p=%h", p8);
      end else begin
        logic [15:0] e;
        e = exp8q.pop_front();
        if (p8 !== e || busy8 !== 1'b0) begin
          errors++;
          $display("FAIL w8_product got p=%h busy=%b want p=%h busy=0", p8, busy8, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      checks++;
      if (exp16q.size() == 0) begin
        errors++;
        $display("FAIL w16_unexpected_done p=%h", p16);
      end else begin
        logic [31:0] e;
        e = exp16q.pop_front();
        if (p16 !== e || busy16 !== 1'b0) begin
          errors++;
          $display("FAIL w16_product got p=%h busy=%b want p=%h busy=0", p16, busy16, e);
        end
      end
    end
  end

  // Count edges (starting from base) until done4 is seen, bounded.
  task automatic wait_done4(input int base, output int at);
    at = base;
    do begin
      @(posedge clk);
      #1;
      at++;
    end while (!done4 && at < base + 40);
    if (!done4) begin
      errors++;
      $display("FAIL w4_done_timeout after %0d edges", at);
    end
  endtask

  task automatic run_op4(input logic s, input logic [3:0] b, input logic [3:0] q,
                         input logic [7:0] e);
    int lat;
    exp4q.push_back(e);
    start4 = 1'b1; sm4 = s; b4 = b; q4 = q;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done4(0, lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL w4_latency got %0d want 5 (b=%h q=%h s=%b)", lat, b, q, s);
    end
  endtask

  task automatic run_op8(input logic s, input logic [7:0] b, input logic [7:0] q);
    int n;
    exp8q.push_back(16'(ref_mul(s, 8, 64'(b), 64'(q))));
    start8 = 1'b1; sm8 = s; b8 = b; q8 = q;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done8) begin
      errors++;
      $display("FAIL w8_done_timeout b=%h q=%h", b, q);
    end
  endtask

  task automatic run_op16(input logic s, input logic [15:0] b, input logic [15:0] q);
    int n;
    exp16q.push_back(32'(ref_mul(s, 16, 64'(b), 64'(q))));
    start16 = 1'b1; sm16 = s; b16 = b; q16 = q;
    @(posedge clk);
    #1 start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done16) begin
      errors++;
      $display("FAIL w16_done_timeout b=%h q=%h", b, q);
    end
  endtask

  initial begin
    int t1, t2;

    tbl[0] = '{1'b0, 4'hF, 4'hF, 8'hE1};
    tbl[1] = '{1'b0, 4'h0, 4'h9, 8'h00};
    tbl[2] = '{1'b0, 4'h1, 4'hF, 8'h0F};
    tbl[3] = '{1'b1, 4'h8, 4'h8, 8'h40};
    tbl[4] = '{1'b1, 4'h8, 4'h7, 8'hC8};
    tbl[5] = '{1'b1, 4'h7, 4'hF, 8'hF9};
    tbl[6] = '{1'b1, 4'hF, 4'hF, 8'h01};

    // Reset, then stay idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got busy=%b done=%b p=%h want 0 0 00",
                 i, busy4, done4, p4);
      end
    end

    // Corner vectors.
    for (int i = 0; i < 7; i++)
      run_op4(tbl[i].s, tbl[i].b, tbl[i].q, tbl[i].p);
    @(posedge clk);
    #1;

    // start and new operands during busy are ignored: 3x5 stays 15.
    exp4q.push_back(8'h0F);
    start4 = 1'b1; sm4 = 1'b0; b4 = 4'd3; q4 = 4'd5;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    #1 start4 = 1'b1; sm4 = 1'b1; b4 = 4'hF; q4 = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done4(3, t1);
    checks++;
    if (t1 != 5) begin
      errors++;
      $display("FAIL busy_ignore_latency got %0d want 5", t1);
    end
    @(posedge clk);
    #1;

    // Back-to-back: start held through DONE, results 6 cycles apart.
    exp4q.push_back(8'd6);
    exp4q.push_back(8'd20);
    start4 = 1'b1; sm4 = 1'b0; b4 = 4'd2; q4 = 4'd3;
    @(posedge clk);
    #1 b4 = 4'd4; q4 = 4'd5;
    wait_done4(0, t1);
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done4(t1 + 1, t2);
    checks++;
    if (t1 != 5 || t2 - t1 != 6) begin
      errors++;
      $display("FAIL back_to_back first=%0d gap=%0d want 5 and 6", t1, t2 - t1);
    end
    @(posedge clk);
    #1;

    // Reset during CALC aborts the operation.
    start4 = 1'b1; sm4 = 1'b0; b4 = 4'd3; q4 = 4'd3;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort got busy=%b done=%b p=%h want 0 0 00", busy4, done4, p4);
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    run_op4(1'b0, 4'd3, 4'd3, 8'h09);

    // Exhaustive WIDTH=4, both modes.
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 16; b++)
        for (int q = 0; q < 16; q++)
          run_op4(s[0], b[3:0], q[3:0], 8'(ref_mul(s[0], 4, 64'(b), 64'(q))));
    @(posedge clk);
    #1;

    // Random WIDTH=8 and WIDTH=16, with the extreme operands first.
    run_op8(1'b1, 8'h80, 8'h80);
    run_op8(1'b0, 8'hFF, 8'hFF);
    run_op16(1'b1, 16'h8000, 16'h8000);
    run_op16(1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 1000; i++)
      run_op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 1000; i++)
      run_op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    repeat (3) @(posedge clk);
    @(negedge clk);

    checks++;
    if (exp4q.size() != 0 || exp8q.size() != 0 || exp16q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left w4=%0d w8=%0d w16=%0d want 0 0 0",
               exp4q.size(), exp8q.size(), exp16q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_booth.md
# multiplicador_booth

Sequential multiplier with signed/unsigned mode and a busy/done handshake. It is the generalised successor of the shift-and-add unsigned multiplier. Radix-2 Booth recoding over operands extended by one bit handles both two's-complement and unsigned operands in one datapath with a fixed, data-independent latency. It sits beside the existing arithmetic blocks as a drop-in for any WIDTH, with operands captured at start so the inputs may change while it runs.

## Interface
- WIDTH, default 4: operand width in bits; legal values are ≥ 2.
- clk  input  1  clock; everything updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a multiplication; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned. Sampled together with start.
- B_in  input  WIDTH  multiplicand, sampled on the accepting edge.
- Q_in  input  WIDTH  multiplier, sampled on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  high for exactly one cycle when P_out holds a new result.
- P_out  output  2*WIDTH  product register; holds its value until the next result is written.

## Operation
- Internal width is E = WIDTH+1. On acceptance:
  - B and Q are extended to E bits: sign-extended if signed_mode = 1, zero-extended otherwise.
  - A (E bits) is cleared.
  - The Booth bit q_-1 is cleared.
  - The counter is loaded with E.
- States:
  - IDLE: wait for start. start = 1 → CALC and load the operands.
  - CALC: one Booth step per cycle, then decrement the counter. When the counter reaches 0 after this step → DONE.
  - DONE: done = 1. start = 1 → CALC (back-to-back accept). Otherwise → IDLE.
- Booth step, on {Q[0], q_-1}:
  - 10: A = A − B.
  - 01: A = A + B.
  - 00 and 11: no change.
  - Then arithmetic right shift of the concatenation {A, Q, q_-1} by 1, with the MSB of A replicated.
- Arithmetic is modulo 2^E in A; overflow from the add/subtract is discarded, which is correct for Booth.
- Result: the full 2E-bit product is {A, Q}, and P_out is its low 2*WIDTH bits.
  - This is exact in both modes. The signed range is −2^(WIDTH−1) … 2^(WIDTH−1)−1; the unsigned range is 0 … 2^WIDTH−1.
  - The most-negative × most-negative case, (−2^(W−1))², must produce +2^(2W−2) without overflow.
- P_out is written on the edge entering DONE and only then.
- start while busy = 1 is ignored. Operands and mode of the running operation are unaffected.
- signed_mode, B_in and Q_in are don't-care except on the accepting edge.

## Timing
- Reset values: state IDLE, busy = 0, done = 0, P_out = 0, internal A/B/Q/counter = 0.
- rst has priority over start on the same edge. rst during CALC or DONE aborts the operation: the next cycle is IDLE with every output at its reset value, and no done is produced for the aborted operation.
- Numbering: the accepting edge is edge 0. Edges 1 … WIDTH+1 perform the E Booth steps.
- busy is high from after edge 0 until edge WIDTH+1.
- done and the new P_out are visible from edge WIDTH+1. done falls at edge WIDTH+2.
- Latency from the accepting edge to done is WIDTH+1 cycles: 5 cycles for WIDTH = 4.
- Back-to-back: with start = 1 during DONE, the next operation's edge 0 is that DONE edge. Throughput is one result every WIDTH+2 cycles.
- busy and done are never high simultaneously. done is a single-cycle pulse, never held.

## Test plan
- Reset then idle: rst for 2 cycles, start = 0 → busy = 0, done = 0, P_out = 8'h00 for 10 cycles.
- Unsigned corners, WIDTH = 4, signed_mode = 0:
  - 15×15 → P_out = 8'hE1.
  - 0×9 → 8'h00.
  - 1×15 → 8'h0F.
  - In each case done occurs exactly 5 cycles after start.
- Signed corners, signed_mode = 1:
  - −8×−8 → 8'h40.
  - −8×7 → 8'hC8.
  - 7×−1 → 8'hF9.
  - −1×−1 → 8'h01.
- Handshake:
  - start re-asserted and B_in/Q_in changed during busy → ignored; the result equals that of the originally captured operands.
  - start held high through DONE → the next result appears 6 cycles after the previous done.
- Reset mid-operation: rst at cycle 2 of CALC for 3×3 → no done pulse, P_out = 0. A following 3×3 yields 8'h09 with normal latency.
- Exhaustive: WIDTH = 4, both modes, all 256 operand pairs checked against a reference product. Random run at WIDTH = 8 and WIDTH = 16 with at least 1000 pairs each.
